// File: rtl/comm_chan_bank.sv
// ============================================================================
// Module   : comm_chan_bank
// Purpose  : EPP channel back-end: 8-bit register bank plus rx/tx streaming FIFOs.
//            Optional read-only status channel at FIFO_CHAN+1 via COMM_STATUS_CHAN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comm_chan_bank #(
    parameter int          NUM_REGS   = 4,
    parameter logic [6:0]  FIFO_CHAN  = 7'h10,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [6:0]              chanAddr_in,
    input  logic [7:0]              h2fData_in,
    input  logic                    h2fValid_in,
    output logic                    h2fReady_out,
    output logic [7:0]              f2hData_out,
    output logic                    f2hValid_out,
    input  logic                    f2hReady_in,
    output logic [8*NUM_REGS-1:0]   regs_out,
    output logic [7:0]              rxData_out,
    output logic                    rxValid_out,
    input  logic                    rxReady_in,
    input  logic [7:0]              txData_in,
    input  logic                    txValid_in,
    output logic                    txReady_out,
    output logic [DEPTH_LOG2:0]     rxCount_out,
    output logic [DEPTH_LOG2:0]     txCount_out
);

    localparam int                 c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL    = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [6:0]         c_NUM_REGS = 7'(NUM_REGS);
    localparam int                 c_RX       = 0;
    localparam int                 c_TX       = 1;
`ifdef COMM_STATUS_CHAN_EN
    localparam logic [6:0]         c_STATUS_CHAN = FIFO_CHAN + 7'd1;
`endif

    logic [8*NUM_REGS-1:0]          r_regs;
    logic                           w_is_reg;
    logic                           w_is_fifo;
    logic                           w_h2f_xfer;
    logic [7:0]                     w_f2h_data;
    logic [1:0]                     w_fifo_push;
    logic [1:0]                     w_fifo_pop;
    logic [1:0]                     w_fifo_full;
    logic [1:0]                     w_fifo_empty;
    logic [1:0][7:0]                w_fifo_din;
    logic [1:0][7:0]                w_fifo_head;
    logic [1:0][DEPTH_LOG2:0]       w_fifo_count;

    assign w_is_reg  = (chanAddr_in < c_NUM_REGS);
    assign w_is_fifo = (chanAddr_in == FIFO_CHAN);

    // Handshake flags depend only on address and FIFO state, never on the partner's valid/ready.
    assign h2fReady_out = reset_in & (w_is_fifo ? ~w_fifo_full[c_RX] : 1'b1);
    assign f2hValid_out = reset_in & (w_is_fifo ? ~w_fifo_empty[c_TX] : 1'b1);
    assign rxValid_out  = reset_in & ~w_fifo_empty[c_RX];
    assign txReady_out  = reset_in & ~w_fifo_full[c_TX];

    assign w_h2f_xfer = h2fValid_in & h2fReady_out;

    assign w_fifo_din[c_RX]  = h2fData_in;
    assign w_fifo_din[c_TX]  = txData_in;
    assign w_fifo_push[c_RX] = w_h2f_xfer & w_is_fifo;
    assign w_fifo_push[c_TX] = txValid_in & txReady_out;
    assign w_fifo_pop[c_RX]  = rxReady_in & rxValid_out;
    assign w_fifo_pop[c_TX]  = f2hValid_out & f2hReady_in & w_is_fifo;

    always_comb begin
        w_f2h_data = 8'h00;
        if (w_is_fifo) begin
            w_f2h_data = w_fifo_head[c_TX];
`ifdef COMM_STATUS_CHAN_EN
        end else if (chanAddr_in == c_STATUS_CHAN) begin
            w_f2h_data = {w_fifo_full[c_RX], w_fifo_empty[c_RX],
                          w_fifo_full[c_TX], w_fifo_empty[c_TX], 4'b0000};
`endif
        end else if (w_is_reg) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (chanAddr_in == 7'(k)) begin
                    w_f2h_data = r_regs[8*k +: 8];
                end
            end
        end
    end

    assign f2hData_out = w_f2h_data;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_regs <= '0;
        end else if (w_h2f_xfer && w_is_reg) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (chanAddr_in == 7'(k)) begin
                    r_regs[8*k +: 8] <= h2fData_in;
                end
            end
        end
    end

    assign regs_out = r_regs;

    // Index 0 is rx (host -> app), index 1 is tx (app -> host); both first-word-fall-through.
    for (genvar i = 0; i < 2; i++) begin : g_fifo
        logic [7:0]            r_mem [c_DEPTH];
        logic [DEPTH_LOG2:0]   r_wr;
        logic [DEPTH_LOG2:0]   r_rd;
        logic [DEPTH_LOG2:0]   r_count;
        logic                  w_push;
        logic                  w_pop;

        assign w_fifo_full[i]  = (r_count == c_FULL);
        assign w_fifo_empty[i] = (r_count == '0);
        assign w_push          = w_fifo_push[i] & ~w_fifo_full[i];
        assign w_pop           = w_fifo_pop[i] & ~w_fifo_empty[i];
        assign w_fifo_head[i]  = r_mem[r_rd[DEPTH_LOG2-1:0]];
        assign w_fifo_count[i] = r_count;

        always_ff @(posedge clk_in) begin
            if (!reset_in) begin
                r_wr    <= '0;
                r_rd    <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wr <= r_wr + 1'b1;
                end
                if (w_pop) begin
                    r_rd <= r_rd + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        always_ff @(posedge clk_in) begin
            if (reset_in && w_push) begin
                r_mem[r_wr[DEPTH_LOG2-1:0]] <= w_fifo_din[i];
            end
        end
    end

    assign rxData_out  = w_fifo_head[c_RX];
    assign rxCount_out = w_fifo_count[c_RX];
    assign txCount_out = w_fifo_count[c_TX];

endmodule

`default_nettype wire

// File: tb/tb_comm_chan_bank.sv
// ============================================================================
// Module   : tb_comm_chan_bank
// Purpose  : Scoreboard bench for comm_chan_bank (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comm_chan_bank;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [6:0]  chanAddr_in;
    logic [7:0]  h2fData_in;
    logic        h2fValid_in;
    logic        h2fReady_out;
    logic [7:0]  f2hData_out;
    logic        f2hValid_out;
    logic        f2hReady_in;
    logic [31:0] regs_out;
    logic [7:0]  rxData_out;
    logic        rxValid_out;
    logic        rxReady_in;
    logic [7:0]  txData_in;
    logic        txValid_in;
    logic        txReady_out;
    logic [4:0]  rxCount_out;
    logic [4:0]  txCount_out;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [7:0]  f2h_q[$];
    logic [7:0]  rx_q[$];

    comm_chan_bank dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .chanAddr_in  (chanAddr_in),
        .h2fData_in   (h2fData_in),
        .h2fValid_in  (h2fValid_in),
        .h2fReady_out (h2fReady_out),
        .f2hData_out  (f2hData_out),
        .f2hValid_out (f2hValid_out),
        .f2hReady_in  (f2hReady_in),
        .regs_out     (regs_out),
        .rxData_out   (rxData_out),
        .rxValid_out  (rxValid_out),
        .rxReady_in   (rxReady_in),
        .txData_in    (txData_in),
        .txValid_in   (txValid_in),
        .txReady_out  (txReady_out),
        .rxCount_out  (rxCount_out),
        .txCount_out  (txCount_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c;
        c = 0;
        while ((f2h_q.size() != 0 || rx_q.size() != 0) && c < budget) begin
            tick();
            c++;
        end
        chk(name, 32'((f2h_q.size() == 0) && (rx_q.size() == 0)), 32'd1);
    endtask

    // Monitor: a transfer happens on the coming rising edge whenever valid & ready are high now.
    always @(negedge clk_in) begin
        if (f2hValid_out && f2hReady_in) begin
            if (f2h_q.size() == 0) begin
                n_total++;
                $display("FAIL f2h_unexpected: got 0x%0h expected no transfer at %0t", f2hData_out, $time);
            end else begin
                chk("f2h_data", 32'(f2hData_out), 32'(f2h_q.pop_front()));
            end
        end
        if (rxValid_out && rxReady_in) begin
            if (rx_q.size() == 0) begin
                n_total++;
                $display("FAIL rx_unexpected: got 0x%0h expected no transfer at %0t", rxData_out, $time);
            end else begin
                chk("rx_data", 32'(rxData_out), 32'(rx_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic accepted;
        reset_in    = 1'b0;
        chanAddr_in = 7'd0;
        h2fData_in  = 8'h00;
        h2fValid_in = 1'b0;
        f2hReady_in = 1'b0;
        rxReady_in  = 1'b0;
        txData_in   = 8'h00;
        txValid_in  = 1'b0;

        // Reset state
        tick();
        tick();
        @(negedge clk_in);
        chk("rst_h2fReady", 32'(h2fReady_out), 32'd0);
        chk("rst_f2hValid", 32'(f2hValid_out), 32'd0);
        chk("rst_txReady",  32'(txReady_out),  32'd0);
        chk("rst_rxValid",  32'(rxValid_out),  32'd0);
        tick();
        reset_in = 1'b1;
        @(negedge clk_in);
        chk("rst_regs",    regs_out,           32'h0);
        chk("rst_rxCount", 32'(rxCount_out),   32'd0);
        chk("rst_txCount", 32'(txCount_out),   32'd0);
        chk("rst_txReady_rel", 32'(txReady_out), 32'd1);

        // Register writes and readback
        tick();
        chanAddr_in = 7'd2; h2fData_in = 8'hA5; h2fValid_in = 1'b1;
        @(negedge clk_in);
        chk("reg_h2fReady", 32'(h2fReady_out), 32'd1);
        tick();
        chanAddr_in = 7'd3; h2fData_in = 8'h7E;
        @(negedge clk_in);
        chk("reg2_visible", regs_out, 32'h00A5_0000);
        tick();
        h2fValid_in = 1'b0;
        chanAddr_in = 7'd2;
        f2h_q.push_back(8'hA5);
        f2hReady_in = 1'b1;
        @(negedge clk_in);
        chk("reg_regs", regs_out, 32'h7EA5_0000);
        chk("reg_f2hValid", 32'(f2hValid_out), 32'd1);
        tick();
        chanAddr_in = 7'd3;
        f2h_q.push_back(8'h7E);
        tick();
        chanAddr_in = 7'd0;
        f2h_q.push_back(8'h00);
        tick();
        f2hReady_in = 1'b0;

        // Unmapped channel: write discarded, reads 0x00; then the status channel
        chanAddr_in = 7'h50; h2fData_in = 8'hFF; h2fValid_in = 1'b1;
        @(negedge clk_in);
        chk("unmapped_h2fReady", 32'(h2fReady_out), 32'd1);
        tick();
        h2fValid_in = 1'b0;
        f2h_q.push_back(8'h00);
        f2hReady_in = 1'b1;
        @(negedge clk_in);
        chk("unmapped_regs", regs_out, 32'h7EA5_0000);
        tick();
        chanAddr_in = 7'h11;
`ifdef COMM_STATUS_CHAN_EN
        f2h_q.push_back(8'h50);
`else
        f2h_q.push_back(8'h00);
`endif
        tick();
        f2hReady_in = 1'b0;
        wait_drain("reg_reads_done", 4);

        // rx fill to full with the app stalled
        chanAddr_in = 7'h10;
        for (int i = 0; i <= 16; i++) rx_q.push_back(8'(i));
        for (int i = 0; i < 16; i++) begin
            h2fData_in = 8'(i); h2fValid_in = 1'b1;
            @(negedge clk_in);
            chk("rx_fill_ready", 32'(h2fReady_out), 32'd1);
            tick();
        end
        h2fData_in = 8'h10;
        @(negedge clk_in);
        chk("rx_full_ready", 32'(h2fReady_out), 32'd0);
        chk("rx_full_count", 32'(rxCount_out),  32'd16);
        chk("rx_full_valid", 32'(rxValid_out),  32'd1);
        tick();
        rxReady_in = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_in);
            if (h2fValid_in && h2fReady_out) accepted = 1'b1;
            tick();
            if (accepted) h2fValid_in = 1'b0;
            if (accepted && rx_q.size() == 0) break;
        end
        chk("rx_drain_done", {30'd0, accepted, rx_q.size() == 0}, 32'd3);
        rxReady_in = 1'b0;
        @(negedge clk_in);
        chk("rx_empty_count", 32'(rxCount_out), 32'd0);
        chk("rx_empty_valid", 32'(rxValid_out), 32'd0);
        tick();

        // tx stream read by the host
        txData_in = 8'h11; txValid_in = 1'b1;
        @(negedge clk_in);
        chk("tx_ready", 32'(txReady_out), 32'd1);
        chk("tx_f2hValid_empty", 32'(f2hValid_out), 32'd0);
        tick();
        txData_in = 8'h22;
        tick();
        txValid_in = 1'b0;
        @(negedge clk_in);
        chk("tx_count2", 32'(txCount_out), 32'd2);
        chk("tx_f2hValid", 32'(f2hValid_out), 32'd1);
        tick();
        f2h_q.push_back(8'h11);
        f2h_q.push_back(8'h22);
        f2hReady_in = 1'b1;
        wait_drain("tx_two_reads", 10);
        @(negedge clk_in);
        chk("tx_third_wait0", 32'(f2hValid_out), 32'd0);
        tick();
        @(negedge clk_in);
        chk("tx_third_wait1", 32'(f2hValid_out), 32'd0);
        tick();
        f2h_q.push_back(8'h33);
        txData_in = 8'h33; txValid_in = 1'b1;
        tick();
        txValid_in = 1'b0;
        wait_drain("tx_third_read", 10);
        f2hReady_in = 1'b0;
        @(negedge clk_in);
        chk("tx_final_count", 32'(txCount_out), 32'd0);
        tick();

        // Concurrent rx push and pop at a steady fill of 5, wrapping the pointers
        for (int i = 0; i < 5; i++) begin
            h2fData_in = 8'hA0 + 8'(i); h2fValid_in = 1'b1;
            rx_q.push_back(8'hA0 + 8'(i));
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            h2fData_in = 8'hC0 + 8'(i); h2fValid_in = 1'b1; rxReady_in = 1'b1;
            rx_q.push_back(8'hC0 + 8'(i));
            @(negedge clk_in);
            chk("steady_count", 32'(rxCount_out), 32'd5);
            tick();
        end
        h2fValid_in = 1'b0;
        @(negedge clk_in);
        chk("steady_count_end", 32'(rxCount_out), 32'd5);
        tick();
        wait_drain("steady_drain", 20);
        rxReady_in = 1'b0;

        // Reset asserted with both FIFOs partially full
        chanAddr_in = 7'd1; h2fData_in = 8'h5A; h2fValid_in = 1'b1;
        tick();
        chanAddr_in = 7'h10;
        for (int i = 0; i < 3; i++) begin
            h2fData_in = 8'h60 + 8'(i); h2fValid_in = 1'b1;
            txData_in  = 8'h70 + 8'(i); txValid_in  = (i < 2);
            tick();
        end
        h2fValid_in = 1'b0; txValid_in = 1'b0;
        @(negedge clk_in);
        chk("pre_rst_rxCount", 32'(rxCount_out), 32'd3);
        chk("pre_rst_txCount", 32'(txCount_out), 32'd2);
        chk("pre_rst_regs", regs_out, 32'h7EA5_5A00);
        tick();
        reset_in = 1'b0;
        @(negedge clk_in);
        chk("mid_rst_rxValid",  32'(rxValid_out),  32'd0);
        chk("mid_rst_h2fReady", 32'(h2fReady_out), 32'd0);
        tick();
        @(negedge clk_in);
        chk("post_rst_rxCount", 32'(rxCount_out), 32'd0);
        chk("post_rst_txCount", 32'(txCount_out), 32'd0);
        chk("post_rst_regs",    regs_out,         32'h0);
        tick();
        reset_in = 1'b1;
        @(negedge clk_in);
        chk("rel_rxValid",  32'(rxValid_out),  32'd0);
        chk("rel_f2hValid", 32'(f2hValid_out), 32'd0);
        chk("rel_h2fReady", 32'(h2fReady_out), 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
